// File: rtl/icache_dm.sv
// Direct-mapped, read-only instruction cache with sram-like CPU and memory ports.
// Misses refill the whole line from word 0 upward; uncached fetches bypass the arrays.
module icache_dm #(
   parameter int unsigned INDEX_WIDTH  = 6,
   parameter int unsigned OFFSET_WIDTH = 2
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        cpu_inst_req,
   input  logic        cpu_inst_wr,
   input  logic [1:0]  cpu_inst_size,
   input  logic [31:0] cpu_inst_addr,
   input  logic [31:0] cpu_inst_wdata,
   input  logic        uncached,
   input  logic        inv_all,
   output logic [31:0] cpu_inst_rdata,
   output logic        cpu_inst_addr_ok,
   output logic        cpu_inst_data_ok,
   output logic        cache_inst_req,
   output logic        cache_inst_wr,
   output logic [1:0]  cache_inst_size,
   output logic [31:0] cache_inst_addr,
   output logic [31:0] cache_inst_wdata,
   input  logic [31:0] cache_inst_rdata,
   input  logic        cache_inst_addr_ok,
   input  logic        cache_inst_data_ok
);

   localparam int unsigned TAG_WIDTH = 30 - INDEX_WIDTH - OFFSET_WIDTH;
   localparam int unsigned LINES     = 2**INDEX_WIDTH;
   localparam int unsigned WORDS     = 2**OFFSET_WIDTH;

   typedef enum logic [2:0] {
      IDLE, LOOKUP, REFILL_REQ, REFILL_WAIT, UNC_REQ, UNC_WAIT, RESP
   } state_t;

   state_t                  state;
   logic [LINES-1:0]        valid;
   logic [TAG_WIDTH-1:0]    tag_mem  [LINES];
   logic [31:0]             data_mem [LINES*WORDS];
   logic [31:2]             addr_q;
   logic [OFFSET_WIDTH-1:0] cnt;
   logic [OFFSET_WIDTH-1:0] cnt_next;
   logic                    inv_pend;

   logic [TAG_WIDTH-1:0]    req_tag, q_tag;
   logic [INDEX_WIDTH-1:0]  req_idx, q_idx;
   logic [OFFSET_WIDTH-1:0] req_off, q_off;
   logic                    hit_now;
   logic                    fill_we;
   logic                    fill_last;
   logic                    unused_ok;

   assign req_tag   = cpu_inst_addr[31:INDEX_WIDTH+OFFSET_WIDTH+2];
   assign req_idx   = cpu_inst_addr[INDEX_WIDTH+OFFSET_WIDTH+1:OFFSET_WIDTH+2];
   assign req_off   = cpu_inst_addr[OFFSET_WIDTH+1:2];
   assign q_tag     = addr_q[31:INDEX_WIDTH+OFFSET_WIDTH+2];
   assign q_idx     = addr_q[INDEX_WIDTH+OFFSET_WIDTH+1:OFFSET_WIDTH+2];
   assign q_off     = addr_q[OFFSET_WIDTH+1:2];
   assign cnt_next  = cnt + OFFSET_WIDTH'(1);
   assign hit_now   = valid[req_idx] && (tag_mem[req_idx] == req_tag);
   assign fill_we   = (state == REFILL_WAIT) && cache_inst_data_ok;
   assign fill_last = (cnt == '1);

   assign cpu_inst_addr_ok = resetn && (state == IDLE) && !inv_all && !inv_pend;
   assign cache_inst_wr    = 1'b0;
   assign cache_inst_size  = 2'b10;
   assign cache_inst_wdata = '0;
   assign unused_ok        = ^{cpu_inst_wr, cpu_inst_size, cpu_inst_wdata};

   always_ff @(posedge clk) begin
      if (fill_we) begin
         data_mem[{q_idx, cnt}] <= cache_inst_rdata;
         if (fill_last) tag_mem[q_idx] <= q_tag;
      end
   end

   // The hit decision is taken at the address handshake so data_ok can be a
   // registered output that is already high during the LOOKUP cycle.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state            <= IDLE;
         valid            <= '0;
         addr_q           <= '0;
         cnt              <= '0;
         inv_pend         <= 1'b0;
         cpu_inst_data_ok <= 1'b0;
         cpu_inst_rdata   <= '0;
         cache_inst_req   <= 1'b0;
         cache_inst_addr  <= '0;
      end else begin
         if (state != IDLE && inv_all) inv_pend <= 1'b1;
         case (state)
            IDLE: begin
               if (inv_all || inv_pend) begin
                  valid    <= '0;
                  inv_pend <= 1'b0;
               end else if (cpu_inst_req) begin
                  addr_q <= cpu_inst_addr[31:2];
                  if (uncached) begin
                     cache_inst_req  <= 1'b1;
                     cache_inst_addr <= cpu_inst_addr;
                     state           <= UNC_REQ;
                  end else begin
                     state <= LOOKUP;
                     if (hit_now) begin
                        cpu_inst_data_ok <= 1'b1;
                        cpu_inst_rdata   <= data_mem[{req_idx, req_off}];
                     end
                  end
               end
            end
            LOOKUP: begin
               if (cpu_inst_data_ok) begin
                  cpu_inst_data_ok <= 1'b0;
                  state            <= IDLE;
               end else begin
                  // Line is invalid from here until its last word lands.
                  valid[q_idx]    <= 1'b0;
                  cnt             <= '0;
                  cache_inst_req  <= 1'b1;
                  cache_inst_addr <= {q_tag, q_idx, {OFFSET_WIDTH{1'b0}}, 2'b00};
                  state           <= REFILL_REQ;
               end
            end
            REFILL_REQ: begin
               if (cache_inst_addr_ok) begin
                  cache_inst_req <= 1'b0;
                  state          <= REFILL_WAIT;
               end
            end
            REFILL_WAIT: begin
               if (cache_inst_data_ok) begin
                  if (cnt == q_off) cpu_inst_rdata <= cache_inst_rdata;
                  if (fill_last) begin
                     valid[q_idx]     <= 1'b1;
                     cpu_inst_data_ok <= 1'b1;
                     state            <= RESP;
                  end else begin
                     cnt             <= cnt_next;
                     cache_inst_req  <= 1'b1;
                     cache_inst_addr <= {q_tag, q_idx, cnt_next, 2'b00};
                     state           <= REFILL_REQ;
                  end
               end
            end
            UNC_REQ: begin
               if (cache_inst_addr_ok) begin
                  cache_inst_req <= 1'b0;
                  state          <= UNC_WAIT;
               end
            end
            UNC_WAIT: begin
               if (cache_inst_data_ok) begin
                  cpu_inst_rdata   <= cache_inst_rdata;
                  cpu_inst_data_ok <= 1'b1;
                  state            <= RESP;
               end
            end
            RESP: begin
               cpu_inst_data_ok <= 1'b0;
               state            <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm: vector table of fetches against a fixed-latency
// memory model, plus hand sequences for invalidate and mid-refill reset.
module tb_icache_dm;

   logic        clk = 1'b0;
   logic        resetn;
   logic        cpu_req, cpu_wr, unc, inv_all;
   logic [1:0]  cpu_size;
   logic [31:0] cpu_addr, cpu_wdata;
   logic [31:0] rdata;
   logic        aok, dok;
   logic        mreq, mwr;
   logic [1:0]  msize;
   logic [31:0] maddr, mwdata, mrdata;
   logic        maok, mdok;

   int checks = 0;
   int errors = 0;
   logic [31:0] req_log[$];

   icache_dm #(.INDEX_WIDTH(6), .OFFSET_WIDTH(2)) dut (
      .clk(clk), .resetn(resetn),
      .cpu_inst_req(cpu_req), .cpu_inst_wr(cpu_wr), .cpu_inst_size(cpu_size),
      .cpu_inst_addr(cpu_addr), .cpu_inst_wdata(cpu_wdata),
      .uncached(unc), .inv_all(inv_all),
      .cpu_inst_rdata(rdata), .cpu_inst_addr_ok(aok), .cpu_inst_data_ok(dok),
      .cache_inst_req(mreq), .cache_inst_wr(mwr), .cache_inst_size(msize),
      .cache_inst_addr(maddr), .cache_inst_wdata(mwdata),
      .cache_inst_rdata(mrdata), .cache_inst_addr_ok(maok), .cache_inst_data_ok(mdok)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
   endfunction

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endfunction

   // Memory: accepts a request the cycle after it appears, returns data two cycles later.
   initial begin
      logic        pend;
      logic [31:0] pend_addr;
      int          wait_cnt;
      pend = 1'b0; pend_addr = '0; wait_cnt = 0;
      maok = 1'b0; mdok = 1'b0; mrdata = '0;
      forever begin
         @(posedge clk); #1;
         maok = 1'b0; mdok = 1'b0;
         if (!resetn) begin
            pend = 1'b0;
         end else if (pend) begin
            if (wait_cnt == 0) begin
               mdok = 1'b1; mrdata = mem_word(pend_addr); pend = 1'b0;
            end else wait_cnt--;
         end else if (mreq) begin
            maok = 1'b1; pend = 1'b1; pend_addr = maddr; wait_cnt = 1;
            req_log.push_back(maddr);
         end
      end
   end

   task automatic fetch(input logic [31:0] a, input logic u, output int lat,
                        output logic [31:0] d, output logic dok_after, output logic aok_after);
      int n;
      lat = -1; d = '0; dok_after = 1'b1; aok_after = 1'b0;
      @(posedge clk); #1;
      cpu_req = 1'b1; cpu_addr = a; unc = u;
      n = 0;
      @(negedge clk);
      while (!aok && n < 20) begin @(negedge clk); n++; end
      if (!aok) begin
         cpu_req = 1'b0; unc = 1'b0;
         return;
      end
      @(posedge clk); #1;
      cpu_req = 1'b0; unc = 1'b0;
      n = 0;
      while (n < 100) begin
         @(negedge clk); n++;
         if (dok) begin
            lat = n; d = rdata;
            @(negedge clk);
            dok_after = dok; aok_after = aok;
            return;
         end
      end
   endtask

   task automatic run_vec(input string name, input logic [31:0] a, input logic u,
                          input int nreq, input int exp_lat, input logic exp_aok);
      int lat;
      logic [31:0] d;
      logic da, aa;
      logic [31:0] base;
      req_log.delete();
      fetch(a, u, lat, d, da, aa);
      chk({name, "_lat"}, lat, exp_lat);
      chk({name, "_data"}, d, mem_word({a[31:2], 2'b00}));
      chk({name, "_pulse"}, {31'd0, da}, 32'd0);
      chk({name, "_aok_after"}, {31'd0, aa}, {31'd0, exp_aok});
      chk({name, "_nreq"}, req_log.size(), nreq);
      base = u ? a : {a[31:4], 4'h0};
      for (int k = 0; k < req_log.size() && k < nreq; k++)
         chk($sformatf("%s_maddr%0d", name, k), req_log[k], base + 32'(4 * k));
   endtask

   typedef struct {
      logic [31:0] addr;
      logic        u;
      int          nreq;
      int          lat;
   } vec_t;

   vec_t vecs[11];

   initial begin
      int seen, n;
      vecs[0]  = '{32'h1FC0_0004, 1'b0, 4, 14};  // cold miss, mid-line word
      vecs[1]  = '{32'h1FC0_000C, 1'b0, 0, 1};   // hit, last word
      vecs[2]  = '{32'h1FC0_0400, 1'b0, 4, 14};  // conflict on index 0
      vecs[3]  = '{32'h1FC0_0000, 1'b0, 4, 14};  // evicted, misses again
      vecs[4]  = '{32'h1FC0_0008, 1'b1, 1, 4};   // uncached bypass
      vecs[5]  = '{32'h1FC0_0008, 1'b0, 0, 1};   // cached line untouched
      vecs[6]  = '{32'h1FC0_0010, 1'b0, 4, 14};  // index 1, word 0
      vecs[7]  = '{32'h1FC0_001C, 1'b0, 0, 1};
      vecs[8]  = '{32'h1FC0_03FC, 1'b0, 4, 14};  // top index, top offset
      vecs[9]  = '{32'h1FC0_03F0, 1'b0, 0, 1};
      vecs[10] = '{32'h1FC0_0004, 1'b0, 0, 1};

      resetn = 1'b0; cpu_req = 1'b0; cpu_wr = 1'b0; cpu_size = 2'b10;
      cpu_addr = '0; cpu_wdata = '0; unc = 1'b0; inv_all = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_data_ok", {31'd0, dok}, 32'd0);
      chk("rst_mreq", {31'd0, mreq}, 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_maddr", maddr, 32'd0);
      chk("rst_addr_ok", {31'd0, aok}, 32'd0);
      resetn = 1'b1;
      @(negedge clk);
      chk("idle_addr_ok", {31'd0, aok}, 32'd1);
      chk("mem_wr", {31'd0, mwr}, 32'd0);
      chk("mem_size", {30'd0, msize}, 32'd2);
      chk("mem_wdata", mwdata, 32'd0);

      for (int i = 0; i < 11; i++)
         run_vec($sformatf("v%0d", i), vecs[i].addr, vecs[i].u, vecs[i].nreq, vecs[i].lat, 1'b1);

      // inv_all in IDLE blocks the concurrent request and drops every line
      req_log.delete();
      @(posedge clk); #1;
      inv_all = 1'b1; cpu_req = 1'b1; cpu_addr = 32'h1FC0_0004;
      @(negedge clk);
      chk("inv_idle_aok", {31'd0, aok}, 32'd0);
      @(posedge clk); #1;
      inv_all = 1'b0; cpu_req = 1'b0;
      @(negedge clk);
      chk("inv_idle_aok_back", {31'd0, aok}, 32'd1);
      chk("inv_idle_noreq", req_log.size(), 0);
      run_vec("inv_idle_refetch", 32'h1FC0_0004, 1'b0, 4, 14, 1'b1);

      // inv_all during REFILL_WAIT is held pending until the next IDLE cycle
      fork
         run_vec("inv_pend_fill", 32'h1FC0_0020, 1'b0, 4, 14, 1'b0);
         begin
            n = 0;
            @(negedge clk);
            while (!maok && n < 50) begin @(negedge clk); n++; end
            chk("inv_pend_saw_aok", {31'd0, maok}, 32'd1);
            @(posedge clk); #1 inv_all = 1'b1;
            @(posedge clk); #1 inv_all = 1'b0;
         end
      join
      run_vec("inv_pend_idx0", 32'h1FC0_0000, 1'b0, 4, 14, 1'b1);
      run_vec("inv_pend_idx2", 32'h1FC0_0020, 1'b0, 4, 14, 1'b1);

      // reset after two refill words leaves the line invalid
      @(posedge clk); #1;
      cpu_req = 1'b1; cpu_addr = 32'h1FC0_0044;
      @(negedge clk);
      chk("rstmid_aok", {31'd0, aok}, 32'd1);
      @(posedge clk); #1 cpu_req = 1'b0;
      seen = 0; n = 0;
      while (seen < 2 && n < 100) begin
         @(negedge clk); n++;
         if (mdok) seen++;
      end
      chk("rstmid_two_words", seen, 2);
      @(posedge clk); #2;
      resetn = 1'b0;
      #1;
      chk("rstmid_data_ok", {31'd0, dok}, 32'd0);
      chk("rstmid_mreq", {31'd0, mreq}, 32'd0);
      chk("rstmid_rdata", rdata, 32'd0);
      chk("rstmid_maddr", maddr, 32'd0);
      chk("rstmid_aok0", {31'd0, aok}, 32'd0);
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      run_vec("rstmid_refetch", 32'h1FC0_0044, 1'b0, 4, 14, 1'b1);
      run_vec("rstmid_hit", 32'h1FC0_0048, 1'b0, 0, 1, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
